// File: rtl/mem_access.sv
// Memory-stage access unit: issues one word-aligned request per load/store, holds the
// producer while the request is outstanding, and forms the MEM_WB writeback.
module mem_access (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_dout_rs2,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_regwrite,
  input  logic [4:0]  EX_MEM_loadcntrl,
  input  logic [2:0]  EX_MEM_storecntrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_hold,
  output logic        MEM_WB_regwrite,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] WB_res,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  ld_q, ld_d;
  logic        rw_q, rw_d;
  logic        wb_rw_q, wb_rw_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_res_q, wb_res_d;
  logic        mis_q, mis_d;

  logic        access, is_half, is_word, misaligned;
  logic [1:0]  off;

  function automatic logic [31:0] load_extract(input logic [4:0]  ld,
                                               input logic [31:0] word,
                                               input logic [1:0]  o);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    shifted = word >> {o, 3'b000};
    b       = shifted[7:0];
    h       = o[1] ? word[31:16] : word[15:0];
    r       = word;
    if (ld[0])      r = {{24{b[7]}}, b};
    else if (ld[3]) r = {24'h0, b};
    else if (ld[1]) r = {{16{h[15]}}, h};
    else if (ld[4]) r = {16'h0, h};
    else if (ld[2]) r = word;
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] sc, input logic [1:0] o);
    logic [3:0] be;
    be = 4'h0;
    if (sc[0])      be = 4'b0001 << o;
    else if (sc[1]) be = 4'b0011 << o;
    else if (sc[2]) be = 4'hF;
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] sc, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    if (sc[0])      w = {4{d[7:0]}};
    else if (sc[1]) w = {2{d[15:0]}};
    return w;
  endfunction

  assign off    = EX_MEM_alures[1:0];
  assign access = EX_MEM_memread | EX_MEM_memwrite;

  // Access size follows the read side when both read and write are flagged.
  always_comb begin
    if (EX_MEM_memread) begin
      is_half = EX_MEM_loadcntrl[1] | EX_MEM_loadcntrl[4];
      is_word = EX_MEM_loadcntrl[2];
    end else begin
      is_half = EX_MEM_storecntrl[1];
      is_word = EX_MEM_storecntrl[2];
    end
  end

  assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    be_d     = be_q;
    we_d     = we_q;
    rd_d     = rd_q;
    ld_d     = ld_q;
    rw_d     = rw_q;
    wb_rw_d  = wb_rw_q;
    wb_rd_d  = wb_rd_q;
    wb_res_d = wb_res_q;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg) begin
          mis_d = mis_q;
        end else if (access && misaligned) begin
          mis_d   = 1'b1;
          wb_rw_d = 1'b0;
        end else if (access) begin
          addr_d = EX_MEM_alures;
          rd_d   = EX_MEM_rd;
          ld_d   = EX_MEM_loadcntrl;
          rw_d   = EX_MEM_regwrite;
          if (EX_MEM_memread) begin
            we_d    = 1'b0;
            be_d    = 4'hF;
            wdata_d = 32'h0;
          end else begin
            we_d    = 1'b1;
            be_d    = store_be(EX_MEM_storecntrl, off);
            wdata_d = store_wdata(EX_MEM_storecntrl[1:0], EX_MEM_dout_rs2);
          end
          state_d = BUSY;
        end else begin
          wb_rw_d  = EX_MEM_regwrite;
          wb_rd_d  = EX_MEM_rd;
          wb_res_d = EX_MEM_alures;
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          rdata_d = dmem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!dbg) begin
          wb_rd_d = rd_q;
          if (we_q) begin
            wb_rw_d  = 1'b0;
            wb_res_d = addr_q;
          end else begin
            wb_rw_d  = rw_q;
            wb_res_d = load_extract(ld_q, rdata_q, addr_q[1:0]);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state boundary
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      ld_q     <= '0;
      rw_q     <= 1'b0;
      wb_rw_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_res_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      ld_q     <= ld_d;
      rw_q     <= rw_d;
      wb_rw_q  <= wb_rw_d;
      wb_rd_q  <= wb_rd_d;
      wb_res_q <= wb_res_d;
      mis_q    <= mis_d;
    end
  end

  assign dmem_req        = (state_q == BUSY);
  assign dmem_we         = we_q;
  assign dmem_addr       = {addr_q[31:2], 2'b00};
  assign dmem_wdata      = wdata_q;
  assign dmem_be         = be_q;
  assign mem_hold        = ((state_q == IDLE) && access && !misaligned) || (state_q == BUSY);
  assign MEM_WB_regwrite = wb_rw_q;
  assign MEM_WB_rd       = wb_rd_q;
  assign WB_res          = wb_res_q;
  assign misalign        = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_access;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst, dbg;
  logic [31:0] alures, rs2;
  logic [4:0]  rd, lc;
  logic [2:0]  sc;
  logic        memread, memwrite, regwrite;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_hold, wb_rw, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_res;

  mem_access dut (
    .clk(clk), .Rst(Rst), .dbg(dbg),
    .EX_MEM_alures(alures), .EX_MEM_dout_rs2(rs2), .EX_MEM_rd(rd),
    .EX_MEM_memread(memread), .EX_MEM_memwrite(memwrite), .EX_MEM_regwrite(regwrite),
    .EX_MEM_loadcntrl(lc), .EX_MEM_storecntrl(sc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_hold(mem_hold), .MEM_WB_regwrite(wb_rw), .MEM_WB_rd(wb_rd),
    .WB_res(wb_res), .misalign(misalign)
  );

  int errs = 0;
  int checks = 0;
  logic hold_seen;
  int hold_cnt;

  // Transaction model: phase 0 = no request in flight, 1 = waiting on memory,
  // 2 = data returned, waiting to retire into MEM_WB.
  int          ph;
  logic [31:0] m_full, m_addr, m_wdata, m_word, m_res;
  logic [3:0]  m_be;
  logic        m_we, m_isload, m_rw, m_wbrw, m_mis;
  logic [4:0]  m_rd, m_lc, m_wbrd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int size_now();
    if (memread) return (lc[1] | lc[4]) ? 2 : (lc[2] ? 4 : 1);
    return sc[1] ? 2 : (sc[2] ? 4 : 1);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [4:0] k);
    int unsigned off, bt, hf;
    int v;
    off = a % 4;
    bt  = (w >> (8 * off)) & 32'hFF;
    hf  = (w >> (16 * (off / 2))) & 32'hFFFF;
    if (k[0])      v = (bt >= 128) ? int'(bt) - 256 : int'(bt);
    else if (k[3]) v = int'(bt);
    else if (k[1]) v = (hf >= 32768) ? int'(hf) - 65536 : int'(hf);
    else if (k[4]) v = int'(hf);
    else           v = int'(w);
    return 32'(v);
  endfunction

  task automatic model_reset();
    ph = 0; m_full = 0; m_addr = 0; m_wdata = 0; m_word = 0; m_res = 0; m_be = 0;
    m_we = 0; m_isload = 0; m_rw = 0; m_wbrw = 0; m_mis = 0; m_rd = 0; m_lc = 0; m_wbrd = 0;
  endtask

  task automatic model_advance();
    int sz;
    int unsigned off;
    sz  = size_now();
    off = alures % 4;
    if (Rst) begin
      model_reset();
    end else if (ph == 0) begin
      if (dbg) begin
      end else if ((memread || memwrite) && (alures % sz != 0)) begin
        m_mis = 1; m_wbrw = 0;
      end else if (memread || memwrite) begin
        m_mis = 0; m_full = alures; m_addr = alures & ~32'h3;
        m_isload = memread; m_we = !memread; m_rd = rd; m_rw = regwrite; m_lc = lc;
        if (memread) begin
          m_be = 4'hF; m_wdata = 0;
        end else if (sz == 1) begin
          m_be = 4'(1 << off); m_wdata = (rs2 & 32'hFF) * 32'h01010101;
        end else if (sz == 2) begin
          m_be = 4'(3 << off); m_wdata = (rs2 & 32'hFFFF) * 32'h00010001;
        end else begin
          m_be = 4'hF; m_wdata = rs2;
        end
        ph = 1;
      end else begin
        m_mis = 0; m_wbrw = regwrite; m_wbrd = rd; m_res = alures;
      end
    end else if (ph == 1) begin
      m_mis = 0;
      if (dmem_ready) begin m_word = dmem_rdata; ph = 2; end
    end else begin
      m_mis = 0;
      if (!dbg) begin
        m_wbrd = m_rd;
        if (m_isload) begin m_wbrw = m_rw; m_res = exp_load(m_word, m_full, m_lc); end
        else begin m_wbrw = 0; m_res = m_full; end
        ph = 0;
      end
    end
  endtask

  // Inputs are already driven for this cycle; compare, advance model, cross the edge.
  task automatic step();
    logic acc, ok;
    #1;
    acc = memread | memwrite;
    ok  = (alures % size_now()) == 0;
    hold_seen = mem_hold;
    if (hold_seen) hold_cnt++;
    chk("dmem_req", dmem_req, ph == 1);
    chk("dmem_we", dmem_we, m_we);
    chk("dmem_addr", dmem_addr, m_addr);
    chk("dmem_wdata", dmem_wdata, m_wdata);
    chk("dmem_be", dmem_be, m_be);
    chk("mem_hold", mem_hold, (ph == 0 && acc && ok) || ph == 1);
    chk("wb_regwrite", wb_rw, m_wbrw);
    chk("wb_rd", wb_rd, m_wbrd);
    chk("wb_res", wb_res, m_res);
    chk("misalign", misalign, m_mis);
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_nop();
    memread = 0; memwrite = 0; regwrite = 0; rd = 0; alures = 0; rs2 = 0; lc = 0; sc = 0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_be"}, dmem_be, 0);
    chk({tag, "_wbrw"}, wb_rw, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbres"}, wb_res, 0);
    chk({tag, "_mis"}, misalign, 0);
    chk({tag, "_hold"}, mem_hold, 0);
  endtask

  initial begin
    Rst = 1; dbg = 0; dmem_ready = 0; dmem_rdata = 0; hold_seen = 0; hold_cnt = 0;
    set_nop();
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    Rst = 0;
    #1;
    all_zero("reset");

    // ALU pass-through
    regwrite = 1; rd = 5; alures = 32'hDEAD_BEEF;
    step();
    chk("alu_rd", wb_rd, 5);
    chk("alu_res", wb_res, 32'hDEAD_BEEF);
    chk("alu_rw", wb_rw, 1);
    chk("alu_nohold", hold_seen, 0);

    // Misaligned word load
    set_nop(); memread = 1; lc = 5'b00100; alures = 32'h101; rd = 4; regwrite = 1;
    step();
    chk("mis_nohold", hold_seen, 0);
    chk("mis_pulse", misalign, 1);
    chk("mis_noreq", dmem_req, 0);
    chk("mis_rw", wb_rw, 0);
    set_nop();
    step();
    chk("mis_clear", misalign, 0);

    // lb at 0x103, ready on the second request cycle
    set_nop(); memread = 1; lc = 5'b00001; alures = 32'h103; rd = 7; regwrite = 1;
    hold_cnt = 0;
    step();
    chk("lb_req", dmem_req, 1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", dmem_be, 4'hF);
    chk("lb_we", dmem_we, 0);
    step();
    dmem_ready = 1; dmem_rdata = 32'h80FF_0000;
    step();
    dmem_ready = 0; set_nop();
    step();
    chk("lb_res", wb_res, 32'hFFFF_FF80);
    chk("lb_rw", wb_rw, 1);
    chk("lb_rd", wb_rd, 7);
    chk("lb_holdcycles", hold_cnt, 3);

    // sh at 0x202
    set_nop(); memwrite = 1; sc = 3'b010; alures = 32'h202; rs2 = 32'h1234_ABCD;
    rd = 3; regwrite = 1;
    step();
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", dmem_we, 1);
    dmem_ready = 1;
    step();
    dmem_ready = 0; set_nop();
    step();
    chk("sh_rw", wb_rw, 0);

    // lhu at 0x2 with debug freeze while retiring
    set_nop(); regwrite = 1; rd = 9; alures = 32'h1111_1111;
    step();
    set_nop(); memread = 1; lc = 5'b10000; alures = 32'h2; rd = 12; regwrite = 1;
    step();
    dmem_ready = 1; dmem_rdata = 32'h8765_4321;
    step();
    dmem_ready = 0; dbg = 1;
    set_nop(); memread = 1; lc = 5'b00100; alures = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dbg_nohold", hold_seen, 0);
      chk("dbg_res_frozen", wb_res, 32'h1111_1111);
      chk("dbg_rd_frozen", wb_rd, 9);
    end
    dbg = 0; set_nop();
    step();
    chk("lhu_res", wb_res, 32'h0000_8765);
    chk("lhu_rw", wb_rw, 1);
    chk("lhu_rd", wb_rd, 12);

    // Reset during an outstanding load, then a late ready
    set_nop(); memread = 1; lc = 5'b00100; alures = 32'h40; rd = 2; regwrite = 1;
    step();
    chk("abort_busy", dmem_req, 1);
    Rst = 1; set_nop();
    step();
    all_zero("abort_rst");
    Rst = 0; dmem_ready = 1; dmem_rdata = 32'hCAFE_F00D;
    step();
    all_zero("abort_late");
    dmem_ready = 0;

    // Randomized traffic; the producer only advances when not held
    for (int i = 0; i < 3000; i++) begin
      int op;
      Rst        = ($urandom_range(0, 99) == 0);
      dbg        = ($urandom_range(0, 4) == 0);
      dmem_ready = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      if (!hold_seen) begin
        op       = $urandom_range(0, 3);
        memread  = (op == 1) || (op == 3);
        memwrite = (op == 2) || (op == 3);
        lc       = 5'(1 << $urandom_range(0, 4));
        sc       = 3'(1 << $urandom_range(0, 2));
        alures   = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
        rs2      = $urandom;
        rd       = 5'($urandom_range(0, 31));
        regwrite = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
